// File: rtl/adder_eval_pkg.sv
// Shared definitions for the approximate-adder error monitor.
//   state_t    : monitor FSM state encoding
//   DEF_WIDTH  : default operand width of the adder under test
//   DEF_CNT_W  : default sample-counter width
package adder_eval_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_DRAIN  = 2'd2,
    S_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/abs_err_calc.sv
// Combinational error calculator for one adder sample.
//   in1, in2    : operands applied to the approximate adder
//   approx_sum  : result produced by the approximate adder
//   exact_sum   : unsigned in1+in2, one bit wider than the operands
//   abs_err     : |approx_sum - exact_sum|
module abs_err_calc #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   exact_sum,
  output logic [WIDTH:0]   abs_err
);

  always_comb begin
    exact_sum = {1'b0, in1} + {1'b0, in2};
    if (approx_sum >= exact_sum) begin
      abs_err = approx_sum - exact_sum;
    end else begin
      abs_err = exact_sum - approx_sum;
    end
  end

endmodule

// File: rtl/adder_error_monitor.sv
// Error-metric monitor for an approximate adder. A run of num_samples
// operand/result samples is accepted, passed through a two-stage pipeline
// (error calculation, then accumulation) and summarised as mismatch count,
// sum of absolute errors and worst-case error with its operands.
//   clk, rst_n            : clock, synchronous active-low reset
//   start, num_samples    : run request and run length (captured in IDLE)
//   in_valid, in_ready    : sample handshake
//   in1, in2, approx_sum  : sample operands and approximate result
//   busy                  : run in progress (RUN or DRAIN)
//   result_valid, result_ack : report handshake
//   err_cnt, sae, max_ae, wce_in1, wce_in2 : metrics
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start, metrics hold last report
// S_RUN    | accepting samples until the target count
// S_DRAIN  | no new samples, pipeline emptying
// S_REPORT | metrics valid and frozen until result_ack
module adder_error_monitor
  import adder_eval_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [CNT_W-1:0]       num_samples,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in1,
  input  logic [WIDTH-1:0]       in2,
  input  logic [WIDTH:0]         approx_sum,
  output logic                   busy,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic [CNT_W-1:0]       err_cnt,
  output logic [WIDTH+CNT_W:0]   sae,
  output logic [WIDTH:0]         max_ae,
  output logic [WIDTH-1:0]       wce_in1,
  output logic [WIDTH-1:0]       wce_in2
);

  localparam int SAE_W = WIDTH + 1 + CNT_W;

  state_t             r_state;
  logic [CNT_W-1:0]   r_remain;
  logic               r_in_ready;
  logic               r_busy;
  logic               r_result_valid;

  logic               r_s1_valid;
  logic               r_s1_err;
  logic [WIDTH:0]     r_s1_abs;
  logic [WIDTH-1:0]   r_s1_in1;
  logic [WIDTH-1:0]   r_s1_in2;

  logic [CNT_W-1:0]   r_err_cnt;
  logic [SAE_W-1:0]   r_sae;
  logic [WIDTH:0]     r_max_ae;
  logic [WIDTH-1:0]   r_wce_in1;
  logic [WIDTH-1:0]   r_wce_in2;

  logic               w_accept;
  logic               w_clear;
  logic [WIDTH:0]     w_exact;
  logic [WIDTH:0]     w_abs;

  assign w_accept = in_valid && r_in_ready;
  assign w_clear  = (r_state == S_IDLE) && start;

  abs_err_calc #(.WIDTH(WIDTH)) u_abs_err_calc (
    .in1        (in1),
    .in2        (in2),
    .approx_sum (approx_sum),
    .exact_sum  (w_exact),
    .abs_err    (w_abs)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_remain       <= '0;
      r_in_ready     <= 1'b0;
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_s1_valid     <= 1'b0;
      r_s1_err       <= 1'b0;
      r_s1_abs       <= '0;
      r_s1_in1       <= '0;
      r_s1_in2       <= '0;
      r_err_cnt      <= '0;
      r_sae          <= '0;
      r_max_ae       <= '0;
      r_wce_in1      <= '0;
      r_wce_in2      <= '0;
    end else begin
      // Stage 1: capture the sample's error figures.
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_err <= (approx_sum != w_exact);
        r_s1_abs <= w_abs;
        r_s1_in1 <= in1;
        r_s1_in2 <= in2;
      end

      // Stage 2: accumulate. Clearing only happens in IDLE, where stage 1
      // is always empty, so the two branches never compete for a sample.
      if (w_clear) begin
        r_err_cnt <= '0;
        r_sae     <= '0;
        r_max_ae  <= '0;
        r_wce_in1 <= '0;
        r_wce_in2 <= '0;
      end else if (r_s1_valid) begin
        r_err_cnt <= r_err_cnt + CNT_W'(r_s1_err);
        r_sae     <= r_sae + SAE_W'(r_s1_abs);
        // Strictly greater: ties keep the earliest worst-case operands.
        if (r_s1_abs > r_max_ae) begin
          r_max_ae  <= r_s1_abs;
          r_wce_in1 <= r_s1_in1;
          r_wce_in2 <= r_s1_in2;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (num_samples != '0) begin
              r_remain   <= num_samples;
              r_state    <= S_RUN;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b1;
            end else begin
              r_state        <= S_REPORT;
              r_result_valid <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_remain <= r_remain - 1'b1;
            if (r_remain == CNT_W'(1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          // Last sample reaches the accumulators on the edge that empties
          // stage 1, so the report is complete one edge later.
          if (!r_s1_valid) begin
            r_state        <= S_REPORT;
            r_busy         <= 1'b0;
            r_result_valid <= 1'b1;
          end
        end
        S_REPORT: begin
          if (result_ack) begin
            r_state        <= S_IDLE;
            r_result_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign err_cnt      = r_err_cnt;
  assign sae          = r_sae;
  assign max_ae       = r_max_ae;
  assign wce_in1      = r_wce_in1;
  assign wce_in2      = r_wce_in2;

endmodule

// File: tb/tb_adder_error_monitor.sv
module tb_adder_error_monitor;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [CNT_W-1:0]     num_samples;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in1;
  logic [WIDTH-1:0]     in2;
  logic [WIDTH:0]       approx_sum;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ack;
  logic [CNT_W-1:0]     err_cnt;
  logic [WIDTH+CNT_W:0] sae;
  logic [WIDTH:0]       max_ae;
  logic [WIDTH-1:0]     wce_in1;
  logic [WIDTH-1:0]     wce_in2;

  adder_error_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .num_samples  (num_samples),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in1          (in1),
    .in2          (in2),
    .approx_sum   (approx_sum),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ack   (result_ack),
    .err_cnt      (err_cnt),
    .sae          (sae),
    .max_ae       (max_ae),
    .wce_in1      (wce_in1),
    .wce_in2      (wce_in2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err_cnt;
    int sae;
    int max_ae;
    int wce1;
    int wce2;
  } exp_t;

  exp_t         exp_q[$];
  bit [7:0]     q1[$];
  bit [7:0]     q2[$];
  bit [8:0]     qa[$];
  int           total = 0;
  int           bad = 0;
  int           n_acc = 0;

  function automatic void add_sample(int a, int b, int apx);
    q1.push_back(a[7:0]);
    q2.push_back(b[7:0]);
    qa.push_back(apx[8:0]);
  endfunction

  // Reference: independent integer arithmetic over the first n samples.
  function automatic exp_t model(int n);
    exp_t e = '{0, 0, 0, 0, 0};
    for (int i = 0; i < n; i++) begin
      int ex = int'(q1[i]) + int'(q2[i]);
      int ap = int'(qa[i]);
      int ae = (ap > ex) ? ap - ex : ex - ap;
      if (ae != 0) e.err_cnt++;
      e.sae += ae;
      if (ae > e.max_ae) begin
        e.max_ae = ae;
        e.wce1 = int'(q1[i]);
        e.wce2 = int'(q2[i]);
      end
    end
    return e;
  endfunction

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = n[CNT_W-1:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_samples(input int n, input bit bubbles);
    int idx = 0;
    int cyc = 0;
    bit acc;
    n_acc = 0;
    while (idx < n && cyc < 2000) begin
      in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
      in1 = q1[idx];
      in2 = q2[idx];
      approx_sum = qa[idx];
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) n_acc++;
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    total++;
    if (idx != n) begin
      $display("FAIL run_samples accepted=%0d required=%0d", idx, n);
      bad++;
    end
  endtask

  // Waits for the report, compares it to the scoreboard head, then acks.
  task automatic wait_report(input string tag, input bit start_with_ack);
    int cyc = 0;
    exp_t e;
    @(negedge clk);
    while (result_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (result_valid !== 1'b1) begin
      $display("FAIL %s report_timeout result_valid=%b required=1", tag, result_valid);
      bad++;
    end
    total++;
    if (exp_q.size() == 0) begin
      $display("FAIL %s scoreboard_empty size=0 required>0", tag);
      bad++;
      return;
    end
    e = exp_q.pop_front();
    total += 5;
    if (err_cnt !== e.err_cnt[CNT_W-1:0]) begin
      $display("FAIL %s err_cnt got=%0d exp=%0d", tag, err_cnt, e.err_cnt); bad++;
    end
    if (sae !== e.sae[WIDTH+CNT_W:0]) begin
      $display("FAIL %s sae got=%0d exp=%0d", tag, sae, e.sae); bad++;
    end
    if (max_ae !== e.max_ae[WIDTH:0]) begin
      $display("FAIL %s max_ae got=%0d exp=%0d", tag, max_ae, e.max_ae); bad++;
    end
    if (wce_in1 !== e.wce1[WIDTH-1:0]) begin
      $display("FAIL %s wce_in1 got=%0d exp=%0d", tag, wce_in1, e.wce1); bad++;
    end
    if (wce_in2 !== e.wce2[WIDTH-1:0]) begin
      $display("FAIL %s wce_in2 got=%0d exp=%0d", tag, wce_in2, e.wce2); bad++;
    end
    @(posedge clk); #1;
    result_ack = 1'b1;
    start = start_with_ack;
    num_samples = 16'd5;
    @(posedge clk); #1;
    result_ack = 1'b0;
    start = 1'b0;
    @(negedge clk);
    total += 3;
    if (result_valid !== 1'b0) begin
      $display("FAIL %s ack_result_valid got=%b exp=0", tag, result_valid); bad++;
    end
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      $display("FAIL %s ack_idle busy=%b in_ready=%b exp=0/0", tag, busy, in_ready); bad++;
    end
    if (err_cnt !== e.err_cnt[CNT_W-1:0] || sae !== e.sae[WIDTH+CNT_W:0]) begin
      $display("FAIL %s idle_hold err_cnt=%0d sae=%0d exp=%0d/%0d", tag, err_cnt, sae, e.err_cnt, e.sae);
      bad++;
    end
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    total++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || in_ready !== 1'b0 ||
        err_cnt !== '0 || sae !== '0 || max_ae !== '0 ||
        wce_in1 !== '0 || wce_in2 !== '0) begin
      $display("FAIL %s outputs busy=%b rv=%b rdy=%b err=%0d sae=%0d max=%0d wce=%0d,%0d exp all 0",
               tag, busy, result_valid, in_ready, err_cnt, sae, max_ae, wce_in1, wce_in2);
      bad++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    num_samples = '0;
    in_valid = 1'b0;
    in1 = '0;
    in2 = '0;
    approx_sum = '0;
    result_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_error();
    q1.delete(); q2.delete(); qa.delete();
    add_sample(1, 1, 2);
    add_sample(5, 3, 8);
    add_sample(0, 0, 0);
    exp_q.push_back(model(3));
    do_start(3);
    run_samples(3, 1'b0);
    wait_report("zero_error", 1'b0);
  endtask

  task automatic test_single_mismatch();
    q1.delete(); q2.delete(); qa.delete();
    add_sample(3, 0, 4);
    add_sample(2, 2, 4);
    exp_q.push_back('{1, 1, 1, 3, 0});
    do_start(2);
    run_samples(2, 1'b0);
    wait_report("single_mismatch", 1'b0);
  endtask

  task automatic test_tie_and_max();
    q1.delete(); q2.delete(); qa.delete();
    add_sample(3, 0, 4);
    add_sample(10, 0, 8);
    add_sample(12, 0, 14);
    exp_q.push_back('{3, 5, 2, 10, 0});
    do_start(3);
    run_samples(3, 1'b0);
    // Report for this run is checked with start coinciding with the ack;
    // the monitor must stay idle afterwards.
    wait_report("tie_and_max", 1'b1);
  endtask

  task automatic test_empty_run();
    exp_q.push_back('{0, 0, 0, 0, 0});
    do_start(0);
    @(negedge clk);
    total += 2;
    if (result_valid !== 1'b1) begin
      $display("FAIL empty_run rv_next_cycle got=%b exp=1", result_valid); bad++;
    end
    if (in_ready !== 1'b0) begin
      $display("FAIL empty_run in_ready got=%b exp=0", in_ready); bad++;
    end
    @(posedge clk); #1;
    wait_report("empty_run", 1'b0);
  endtask

  task automatic test_backpressure();
    int extra = 0;
    q1.delete(); q2.delete(); qa.delete();
    for (int i = 0; i < 100; i++) begin
      int a = $urandom_range(0, 255);
      int b = $urandom_range(0, 255);
      int apx = ($urandom_range(0, 1) == 0) ? a + b : $urandom_range(0, 511);
      add_sample(a, b, apx);
    end
    exp_q.push_back(model(100));
    do_start(100);
    run_samples(100, 1'b1);
    total++;
    if (n_acc != 100) begin
      $display("FAIL backpressure accepts got=%0d exp=100", n_acc); bad++;
    end
    in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (in_ready) extra++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    total++;
    if (extra != 0) begin
      $display("FAIL backpressure ready_after_last got=%0d exp=0", extra); bad++;
    end
    wait_report("backpressure", 1'b0);
  endtask

  task automatic test_reset_midrun();
    q1.delete(); q2.delete(); qa.delete();
    for (int i = 0; i < 10; i++) add_sample(i + 20, 7, i + 30);
    do_start(10);
    run_samples(5, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_zero_outputs("reset_midrun");
    @(posedge clk); #1;
    q1.delete(); q2.delete(); qa.delete();
    add_sample(100, 50, 140);
    add_sample(9, 9, 18);
    add_sample(200, 55, 259);
    exp_q.push_back(model(3));
    do_start(3);
    run_samples(3, 1'b0);
    wait_report("after_reset", 1'b0);
  endtask

  initial begin
    test_reset();
    test_zero_error();
    test_single_mismatch();
    test_tie_and_max();
    test_empty_run();
    test_backpressure();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width of the adder under test.
REQ-002 SHALL have parameter CNT_W, default 16, sample-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a measurement run.
REQ-006 SHALL have port num_samples  input  CNT_W  samples per run, sampled on start.
REQ-007 SHALL have port in_valid  input  1  sample offered.
REQ-008 SHALL have port in_ready  output  1  sample accepted when in_valid&&in_ready.
REQ-009 SHALL have port in1, in2  input  WIDTH  operands applied to the approximate adder.
REQ-010 SHALL have port approx_sum  input  WIDTH+1  approximate adder result for in1,in2.
REQ-011 SHALL have port busy  output  1  high in RUN and DRAIN.
REQ-012 SHALL have port result_valid  output  1  metrics stable and valid.
REQ-013 SHALL have port result_ack  input  1  consumer has taken the metrics.
REQ-014 SHALL have port err_cnt  output  CNT_W  samples with approx_sum != exact sum.
REQ-015 SHALL have port sae  output  WIDTH+1+CNT_W  sum of absolute errors.
REQ-016 SHALL have port max_ae  output  WIDTH+1  worst-case absolute error.
REQ-017 SHALL have port wce_in1, wce_in2  output  WIDTH  operands of the first sample reaching max_ae.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN, REPORT.
REQ-019 IDLE: start=1 and num_samples>0 -> clear metrics, load target, go RUN; start=1 and num_samples=0 -> clear metrics, go REPORT.
REQ-020 RUN: in_ready=1; after the num_samples-th accepted sample -> DRAIN; in_ready=0 in every other state.
REQ-021 Exact sum SHALL be the unsigned in1+in2, WIDTH+1 bits; abs error = |approx_sum - exact|, WIDTH+1 bits, unsigned.
REQ-022 SHALL be a 2-stage pipeline: stage 1 registers exact sum, abs error and operands; stage 2 updates the accumulators.
REQ-023 DRAIN: wait until both pipeline stages are empty (2 cycles after the last accept) -> REPORT.
REQ-024 REPORT: result_valid=1 and metric outputs held constant; result_ack=1 -> IDLE with result_valid=0 the next cycle.
REQ-025 Metric outputs SHALL keep their last values in IDLE until the next start.
REQ-026 start SHALL be ignored outside IDLE, including when it coincides with result_ack in REPORT.
REQ-027 max_ae SHALL update only on strictly greater error; ties keep the earlier wce operands.
REQ-028 sae and err_cnt SHALL not overflow, since the sum of at most 2^CNT_W-1 samples fits their widths; no saturation logic.
REQ-029 Throughput SHALL be one sample per cycle with in_valid held high; bubbles on in_valid SHALL be tolerated.

Reset
REQ-030 rst_n=0 at a clock edge -> state IDLE, pipeline valids 0, all metric outputs 0, busy=0, result_valid=0, in_ready=0.
REQ-031 Reset asserted mid-RUN or DRAIN SHALL discard in-flight samples; no partial report.

Structure
REQ-032 The shared package adder_eval_pkg SHALL hold the FSM state enum and the default WIDTH/CNT_W constants.
REQ-033 A sub-module abs_err_calc (combinational: exact sum and abs error) SHALL be instantiated once in stage 1.

Verification
REQ-034 Zero error: start, num_samples=3; samples (1,1,2),(5,3,8),(0,0,0) -> REPORT: err_cnt=0, sae=0, max_ae=0.
REQ-035 Single mismatch: num_samples=2; (3,0,4),(2,2,4) -> err_cnt=1, sae=1, max_ae=1, wce_in1=3, wce_in2=0.
REQ-036 Tie and max: (3,0,4),(10,0,8),(12,0,14) -> max_ae=2, wce_in1=10, wce_in2=0; sae=5, err_cnt=3.
REQ-037 Empty run: start with num_samples=0 -> result_valid=1 the cycle after start, all metrics 0, no in_ready pulse.
REQ-038 Backpressure and bubbles: random in_valid gaps with num_samples=100 -> exactly 100 accepts, metrics equal the reference model, in_ready=0 from the 100th accept onward.
REQ-039 Reset mid-run: rst_n=0 after 5 of 10 samples -> next cycle IDLE, all outputs 0; a new run then reports only its own samples.
